cve2_obi_arbiter: RTL

Two-to-one arbiter that shares one OBI-style memory port between the CVE2 core's instruction-fetch and data (LSU) interfaces. It sits between the core's bus-side signals and a single-ported SoC memory or bus segment. Each grant is tracked in an in-order ID FIFO, so every rvalid is routed back to the requester that issued the transaction. Arbitration is round-robin with a hold lock, so an accepted-but-ungranted request is never swapped mid-handshake.

---
 rtl/cve2_obi_arb_pkg.sv | 17 +
 rtl/cve2_obi_arb_id_fifo.sv | 60 ++++++
 rtl/cve2_obi_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cve2_obi_arb_pkg.sv
// cve2_obi_arb_pkg: owner IDs and fetch constants shared by the OBI arbiter files.
// Revision 1.0
`default_nettype none

package cve2_obi_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } obi_owner_e;

  // Wide enough for any practical data width; the arbiter slices off what it needs.
  localparam logic [127:0] FETCH_BE = '1;

endpackage

`default_nettype wire

// File: rtl/cve2_obi_arb_id_fifo.sv
// cve2_obi_arb_id_fifo: in-order owner-ID FIFO that routes each rvalid to its requester.
// Revision 1.0
`default_nettype none

module cve2_obi_arb_id_fifo
  import cve2_obi_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic            pop,
  input  obi_owner_e      wdata,
  output obi_owner_e      rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  obi_owner_e      mem [Depth];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap modulo Depth, so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      if (do_push && !do_pop)      count <= count + CntW'(1);
      else if (do_pop && !do_push) count <= count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/cve2_obi_arbiter.sv
// cve2_obi_arbiter: round-robin 2:1 OBI arbiter (fetch vs LSU) with hold lock and in-order response routing.
// Revision 1.0
`default_nettype none

module cve2_obi_arbiter
  import cve2_obi_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_req_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   bus_req_o,
  input  logic                   bus_gnt_i,
  input  logic                   bus_rvalid_i,
  output logic                   bus_we_o,
  output logic [DataWidth/8-1:0] bus_be_o,
  output logic [AddrWidth-1:0]   bus_addr_o,
  output logic [DataWidth-1:0]   bus_wdata_o,
  input  logic [DataWidth-1:0]   bus_rdata_i,
  input  logic                   bus_err_i,
  output logic                   busy_o,
  output logic                   protocol_err_o
);

  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  obi_owner_e      sel;
  obi_owner_e      last_owner;
  obi_owner_e      lock_owner;
  obi_owner_e      head;
  logic            lock;
  logic            sel_req;
  logic            handshake;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;

  always_comb begin
    sel = OWNER_INSTR;
    if (lock)                            sel = lock_owner;
    else if (instr_req_i && data_req_i)  sel = (last_owner == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    else if (data_req_i)                 sel = OWNER_DATA;
  end

  // Full is registered state, so a same-cycle pop cannot re-open the request path.
  assign sel_req   = (sel == OWNER_DATA) ? data_req_i : instr_req_i;
  assign bus_req_o = !rst_i && !full && sel_req;
  assign handshake = bus_req_o && bus_gnt_i;

  assign instr_gnt_o = handshake && (sel == OWNER_INSTR);
  assign data_gnt_o  = handshake && (sel == OWNER_DATA);

  assign bus_we_o    = (sel == OWNER_DATA) ? data_we_i    : 1'b0;
  assign bus_be_o    = (sel == OWNER_DATA) ? data_be_i    : FETCH_BE[BeW-1:0];
  assign bus_addr_o  = (sel == OWNER_DATA) ? data_addr_i  : instr_addr_i;
  assign bus_wdata_o = (sel == OWNER_DATA) ? data_wdata_i : '0;

  assign pop            = !rst_i && bus_rvalid_i && !empty;
  assign instr_rvalid_o = pop && (head == OWNER_INSTR);
  assign data_rvalid_o  = pop && (head == OWNER_DATA);
  assign instr_err_o    = instr_rvalid_o && bus_err_i;
  assign data_err_o     = data_rvalid_o && bus_err_i;
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;
  assign busy_o         = (count != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock           <= 1'b0;
      lock_owner     <= OWNER_INSTR;
      last_owner     <= OWNER_INSTR;
      protocol_err_o <= 1'b0;
    end else begin
      if (handshake) begin
        lock       <= 1'b0;
        last_owner <= sel;
      end else if (bus_req_o) begin
        lock       <= 1'b1;
        lock_owner <= sel;
      end
      if (bus_rvalid_i && empty) protocol_err_o <= 1'b1;
    end
  end

  cve2_obi_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (handshake),
    .pop   (pop),
    .wdata (sel),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

`default_nettype wire
